// File: rtl/decrement.sv
// -----------------------------------------------------------------------------
// decrement
//
// This is a loadable down-counter. While `signal` is held high it steps down
// once every delaySet+1 cycles. A step from 0 wraps to `maxCount`. A step from
// a value above `maxCount` is clamped to `maxCount`. A small IDLE/RUN FSM
// spends one entry cycle before it starts to pace steps with an internal
// delay counter.
//
// Per-cycle priority: load > signal > idle.
//
// Ports
//   clk          : the single clock; all state updates on its rising edge
//   rst          : asynchronous reset, active low
//   delaySet     : [DW] the number of extra held cycles between steps
//   signal       : while high, decrementing is requested
//   load         : a synchronous preset strobe
//   loadValue    : [CW] the preset value; it is clamped to maxCount
//   maxCount     : [CW] the wrap target on underflow
//   decremented  : a one-cycle pulse for each step
//   underflow    : a one-cycle pulse when a step wraps from 0 to maxCount
//   count        : [CW] the current value
//
// Handshake: there is no valid/ready handshake. `signal` is a level request
// that is sampled on every rising edge. Each step produces exactly one cycle of
// `decremented`. No step is held or queued.
// -----------------------------------------------------------------------------
module decrement #(
    parameter int CW = 16,
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [DW-1:0] delaySet,
    input  logic          signal,
    input  logic          load,
    input  logic [CW-1:0] loadValue,
    input  logic [CW-1:0] maxCount,
    output logic          decremented,
    output logic          underflow,
    output logic [CW-1:0] count
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

    state_e        state_q, state_d;
    logic [DW-1:0] delay_q, delay_d;
    logic [CW-1:0] count_q, count_d;
    logic          dec_q, dec_d;
    logic          unf_q, unf_d;

    // Next-state and next-output logic
    always_comb begin
        state_d = state_q;
        delay_d = delay_q;
        count_d = count_q;
        dec_d   = 1'b0;
        unf_d   = 1'b0;

        if (load) begin
            count_d = (loadValue > maxCount) ? maxCount : loadValue;
            delay_d = '0;
            state_d = IDLE;
        end else if (signal) begin
            if (state_q == IDLE) begin
                // The entry cycle only arms the pacing counter; no step is taken.
                state_d = RUN;
                delay_d = '0;
            end else if (delay_q < delaySet) begin
                delay_d = delay_q + DW'(1);
            end else begin
                // The >= comparison also covers a delaySet that was lowered
                // below the running delay. The step fires at once, so delay
                // never stays above delaySet.
                delay_d = '0;
                dec_d   = 1'b1;
                if (count_q == '0) begin
                    count_d = maxCount;
                    unf_d   = 1'b1;
                end else if (count_q > maxCount) begin
                    count_d = maxCount;
                end else begin
                    count_d = count_q - CW'(1);
                end
            end
        end else begin
            state_d = IDLE;
            delay_d = '0;
        end
    end

    // State registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            delay_q <= '0;
            count_q <= '0;
            dec_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            delay_q <= delay_d;
            count_q <= count_d;
            dec_q   <= dec_d;
            unf_q   <= unf_d;
        end
    end

    assign decremented = dec_q;
    assign underflow   = unf_q;
    assign count       = count_q;

endmodule

// File: tb/tb_decrement.sv
// -----------------------------------------------------------------------------
// tb_decrement
//
// This is a directed testbench for the decrement counter. Each scenario task
// drives its own inputs. Expected {decremented, underflow, count} triples are
// computed by hand, and each task compares the DUT outputs against them
// inline, 1 ns after the rising edge.
// -----------------------------------------------------------------------------
module tb_decrement;

    localparam int CW = 16;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [DW-1:0] delaySet = '0;
    logic          signal = 1'b0;
    logic          load = 1'b0;
    logic [CW-1:0] loadValue = '0;
    logic [CW-1:0] maxCount = '0;
    logic          decremented;
    logic          underflow;
    logic [CW-1:0] count;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    decrement #(.CW(CW), .DW(DW)) dut (
        .clk         (clk),
        .rst         (rst),
        .delaySet    (delaySet),
        .signal      (signal),
        .load        (load),
        .loadValue   (loadValue),
        .maxCount    (maxCount),
        .decremented (decremented),
        .underflow   (underflow),
        .count       (count)
    );

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_load(input logic [CW-1:0] v, input logic [CW-1:0] mx);
        signal    = 1'b0;
        load      = 1'b1;
        loadValue = v;
        maxCount  = mx;
        tick();
        load      = 1'b0;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst = 1'b0; load = 1'b1; loadValue = 16'd4; maxCount = 16'd9; signal = 1'b1;
        tick(); tick();
        n_cmp++;
        if ({decremented, underflow, count} !== {1'b0, 1'b0, 16'd0}) begin
            n_err++;
            $display("FAIL reset_hold: dec=%0b unf=%0b count=%0d, required 0 0 0", decremented, underflow, count);
        end
        load = 1'b0; signal = 1'b0;
        rst = 1'b1;
        tick();
        n_cmp++;
        if ({decremented, underflow, count} !== {1'b0, 1'b0, 16'd0}) begin
            n_err++;
            $display("FAIL reset_release: dec=%0b unf=%0b count=%0d, required 0 0 0", decremented, underflow, count);
        end
    endtask

    task automatic test_preset_countdown();
        logic [CW-1:0] ec[13] = '{16'd3, 16'd3, 16'd3, 16'd2, 16'd2, 16'd2, 16'd1,
                                  16'd1, 16'd1, 16'd0, 16'd0, 16'd0, 16'd9};
        logic          ed[13] = '{0, 0, 0, 1, 0, 0, 1, 0, 0, 1, 0, 0, 1};
        logic          eu[13] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1};
        delaySet = 2;
        do_load(16'd3, 16'd9);
        n_cmp++;
        if ({decremented, underflow, count} !== {1'b0, 1'b0, 16'd3}) begin
            n_err++;
            $display("FAIL preset_load: dec=%0b unf=%0b count=%0d, required 0 0 3", decremented, underflow, count);
        end
        signal = 1'b1;
        for (int e = 0; e < 13; e++) begin
            tick();
            n_cmp++;
            if ({decremented, underflow, count} !== {ed[e], eu[e], ec[e]}) begin
                n_err++;
                $display("FAIL preset_countdown edge %0d: dec=%0b unf=%0b count=%0d, required %0b %0b %0d",
                         e, decremented, underflow, count, ed[e], eu[e], ec[e]);
            end
        end
        signal = 1'b0;
        tick();
    endtask

    task automatic test_load_clamp();
        do_load(16'd12, 16'd5);
        n_cmp++;
        if ({decremented, underflow, count} !== {1'b0, 1'b0, 16'd5}) begin
            n_err++;
            $display("FAIL load_clamp: dec=%0b unf=%0b count=%0d, required 0 0 5", decremented, underflow, count);
        end
        do_load(16'd5, 16'd5);
        n_cmp++;
        if (count !== 16'd5) begin
            n_err++;
            $display("FAIL load_equal_max: count=%0d, required 5", count);
        end
        do_load(16'd4, 16'd5);
        n_cmp++;
        if (count !== 16'd4) begin
            n_err++;
            $display("FAIL load_below_max: count=%0d, required 4", count);
        end
    endtask

    task automatic test_zero_delay();
        logic [CW-1:0] ec[5] = '{16'd2, 16'd1, 16'd0, 16'd2, 16'd1};
        logic          ed[5] = '{0, 1, 1, 1, 1};
        logic          eu[5] = '{0, 0, 0, 1, 0};
        delaySet = 0;
        do_load(16'd2, 16'd2);
        signal = 1'b1;
        for (int e = 0; e < 5; e++) begin
            tick();
            n_cmp++;
            if ({decremented, underflow, count} !== {ed[e], eu[e], ec[e]}) begin
                n_err++;
                $display("FAIL zero_delay edge %0d: dec=%0b unf=%0b count=%0d, required %0b %0b %0d",
                         e, decremented, underflow, count, ed[e], eu[e], ec[e]);
            end
        end
        signal = 1'b0;
        tick();
        n_cmp++;
        if ({decremented, underflow, count} !== {1'b0, 1'b0, 16'd1}) begin
            n_err++;
            $display("FAIL zero_delay_stop: dec=%0b unf=%0b count=%0d, required 0 0 1", decremented, underflow, count);
        end
    endtask

    task automatic test_release();
        delaySet = 3;
        do_load(16'd5, 16'd9);
        signal = 1'b1;
        for (int e = 0; e < 4; e++) tick();
        // The step is due on the next edge; drop the request first.
        signal = 1'b0;
        for (int e = 0; e < 2; e++) begin
            tick();
            n_cmp++;
            if ({decremented, underflow, count} !== {1'b0, 1'b0, 16'd5}) begin
                n_err++;
                $display("FAIL release edge %0d: dec=%0b unf=%0b count=%0d, required 0 0 5", e, decremented, underflow, count);
            end
        end
        // Re-raising the request must restart pacing from the entry cycle.
        signal = 1'b1;
        for (int e = 0; e < 4; e++) begin
            tick();
            n_cmp++;
            if ({decremented, underflow, count} !== {1'b0, 1'b0, 16'd5}) begin
                n_err++;
                $display("FAIL rerun_wait edge %0d: dec=%0b unf=%0b count=%0d, required 0 0 5", e, decremented, underflow, count);
            end
        end
        tick();
        n_cmp++;
        if ({decremented, underflow, count} !== {1'b1, 1'b0, 16'd4}) begin
            n_err++;
            $display("FAIL rerun_step: dec=%0b unf=%0b count=%0d, required 1 0 4", decremented, underflow, count);
        end
        signal = 1'b0;
        tick();
    endtask

    task automatic test_priority();
        delaySet = 3;
        do_load(16'd5, 16'd9);
        signal = 1'b1;
        tick(); tick();
        load = 1'b1; loadValue = 16'd7;
        tick();
        n_cmp++;
        if ({decremented, underflow, count} !== {1'b0, 1'b0, 16'd7}) begin
            n_err++;
            $display("FAIL load_wins: dec=%0b unf=%0b count=%0d, required 0 0 7", decremented, underflow, count);
        end
        load = 1'b0; delaySet = 0;
        tick();
        n_cmp++;
        if ({decremented, underflow, count} !== {1'b0, 1'b0, 16'd7}) begin
            n_err++;
            $display("FAIL load_to_idle: dec=%0b unf=%0b count=%0d, required 0 0 7", decremented, underflow, count);
        end
        tick();
        n_cmp++;
        if ({decremented, underflow, count} !== {1'b1, 1'b0, 16'd6}) begin
            n_err++;
            $display("FAIL after_load_step: dec=%0b unf=%0b count=%0d, required 1 0 6", decremented, underflow, count);
        end
        load = 1'b1; loadValue = 16'd12; maxCount = 16'd5;
        tick();
        n_cmp++;
        if ({decremented, underflow, count} !== {1'b0, 1'b0, 16'd5}) begin
            n_err++;
            $display("FAIL load_clamp_with_signal: dec=%0b unf=%0b count=%0d, required 0 0 5", decremented, underflow, count);
        end
        load = 1'b0; signal = 1'b0;
        tick();
    endtask

    task automatic test_maxcount_change();
        do_load(16'd8, 16'd9);
        maxCount = 16'd4; delaySet = 0; signal = 1'b1;
        tick();
        tick();
        n_cmp++;
        if ({decremented, underflow, count} !== {1'b1, 1'b0, 16'd4}) begin
            n_err++;
            $display("FAIL max_change_step: dec=%0b unf=%0b count=%0d, required 1 0 4", decremented, underflow, count);
        end
        tick();
        n_cmp++;
        if ({decremented, underflow, count} !== {1'b1, 1'b0, 16'd3}) begin
            n_err++;
            $display("FAIL max_change_next: dec=%0b unf=%0b count=%0d, required 1 0 3", decremented, underflow, count);
        end
        signal = 1'b0;
        tick();
        // A maxCount of zero makes every step an underflow to zero.
        do_load(16'd5, 16'd0);
        signal = 1'b1;
        tick();
        for (int e = 0; e < 2; e++) begin
            tick();
            n_cmp++;
            if ({decremented, underflow, count} !== {1'b1, 1'b1, 16'd0}) begin
                n_err++;
                $display("FAIL max_zero edge %0d: dec=%0b unf=%0b count=%0d, required 1 1 0", e, decremented, underflow, count);
            end
        end
        signal = 1'b0;
        tick();
    endtask

    task automatic test_delay_change();
        do_load(16'd6, 16'd9);
        delaySet = 4; signal = 1'b1;
        tick(); tick(); tick();
        n_cmp++;
        if ({decremented, underflow, count} !== {1'b0, 1'b0, 16'd6}) begin
            n_err++;
            $display("FAIL delay_change_wait: dec=%0b unf=%0b count=%0d, required 0 0 6", decremented, underflow, count);
        end
        // The delay counter is already 2; lowering delaySet to 1 fires at once.
        delaySet = 1;
        tick();
        n_cmp++;
        if ({decremented, underflow, count} !== {1'b1, 1'b0, 16'd5}) begin
            n_err++;
            $display("FAIL delay_change_step: dec=%0b unf=%0b count=%0d, required 1 0 5", decremented, underflow, count);
        end
        tick();
        n_cmp++;
        if ({decremented, underflow, count} !== {1'b0, 1'b0, 16'd5}) begin
            n_err++;
            $display("FAIL delay_change_gap: dec=%0b unf=%0b count=%0d, required 0 0 5", decremented, underflow, count);
        end
        tick();
        n_cmp++;
        if ({decremented, underflow, count} !== {1'b1, 1'b0, 16'd4}) begin
            n_err++;
            $display("FAIL delay_change_next: dec=%0b unf=%0b count=%0d, required 1 0 4", decremented, underflow, count);
        end
        signal = 1'b0;
        tick();
    endtask

    task automatic test_async_reset();
        do_load(16'd8, 16'd9);
        delaySet = 0; signal = 1'b1;
        tick();
        tick();
        n_cmp++;
        if ({decremented, underflow, count} !== {1'b1, 1'b0, 16'd7}) begin
            n_err++;
            $display("FAIL pre_reset: dec=%0b unf=%0b count=%0d, required 1 0 7", decremented, underflow, count);
        end
        // Assert reset midway between clock edges.
        #2 rst = 1'b0;
        #1;
        n_cmp++;
        if ({decremented, underflow, count} !== {1'b0, 1'b0, 16'd0}) begin
            n_err++;
            $display("FAIL async_reset: dec=%0b unf=%0b count=%0d, required 0 0 0", decremented, underflow, count);
        end
        load = 1'b1; loadValue = 16'd3;
        tick(); tick();
        n_cmp++;
        if ({decremented, underflow, count} !== {1'b0, 1'b0, 16'd0}) begin
            n_err++;
            $display("FAIL reset_held: dec=%0b unf=%0b count=%0d, required 0 0 0", decremented, underflow, count);
        end
        load = 1'b0;
        #2 rst = 1'b1;
        delaySet = 1;
        tick(); tick();
        n_cmp++;
        if ({decremented, underflow, count} !== {1'b0, 1'b0, 16'd0}) begin
            n_err++;
            $display("FAIL resume_wait: dec=%0b unf=%0b count=%0d, required 0 0 0", decremented, underflow, count);
        end
        tick();
        n_cmp++;
        if ({decremented, underflow, count} !== {1'b1, 1'b1, 16'd9}) begin
            n_err++;
            $display("FAIL resume_step: dec=%0b unf=%0b count=%0d, required 1 1 9", decremented, underflow, count);
        end
        signal = 1'b0;
        tick();
    endtask

    initial begin
        test_reset();
        test_preset_countdown();
        test_load_clamp();
        test_zero_delay();
        test_release();
        test_priority();
        test_maxcount_change();
        test_delay_change();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
